// File: rtl/exp_accel_pkg.sv
// Shared register map, CTRL/status bit positions and FSM states for the exponent accelerator.
// Optional modular reduction is selected with EXP_ACCEL_MOD_EN.
package exp_accel_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_BASE   = 3'd1;
  localparam logic [2:0] ADDR_EXP    = 3'd2;
  localparam logic [2:0] ADDR_RESULT = 3'd3;
  localparam logic [2:0] ADDR_MOD    = 3'd4;

  // CTRL write bits
  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CLR_DONE = 2;

  // CTRL read (status) bits
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_OVF    = 2;
  localparam int STAT_IRQ_EN = 3;
  localparam int STAT_ERR    = 4;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    ITER,
    DONE
  } state_e;

endpackage

// File: rtl/exp_accel_mul.sv
// Combinational WIDTH x WIDTH multiply; truncating with overflow flag, or (a*b)%mod when
// EXP_ACCEL_MOD_EN is defined (a zero modulus yields 0 and never flags overflow).
module exp_accel_mul #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef EXP_ACCEL_MOD_EN
  input  logic [WIDTH-1:0] mod_i,
`endif
  output logic [WIDTH-1:0] p_o,
  output logic             ovf_o
);

  logic [2*WIDTH-1:0] full_prod;

  assign full_prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

`ifdef EXP_ACCEL_MOD_EN
  logic [2*WIDTH-1:0] rem;
  assign rem   = (mod_i == '0) ? '0 : full_prod % {{WIDTH{1'b0}}, mod_i};
  assign p_o   = rem[WIDTH-1:0];
  assign ovf_o = 1'b0;
`else
  assign p_o   = full_prod[WIDTH-1:0];
  assign ovf_o = |full_prod[2*WIDTH-1:WIDTH];
`endif

endmodule

// File: rtl/exp_accel_core.sv
// Avalon-MM slave computing BASE^EXP by square-and-multiply, one exponent bit per cycle.
// EXP_ACCEL_MOD_EN adds the MOD register and modular reduction of every product.
module exp_accel_core
  import exp_accel_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_write,
  input  logic [WIDTH-1:0] avs_writedata,
  input  logic             avs_read,
  output logic [WIDTH-1:0] avs_readdata,
  output logic             irq
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     base_q, result_q, result_d, rdata_q, rd_mux;
  logic [WIDTH-1:0]     acc_q, acc_d, b_q, b_d, acc_p, sq_p;
  logic [EXP_WIDTH-1:0] exp_q, e_q, e_d, e_shift;
  logic                 irq_en_q, busy_q, busy_d, done_q, done_d;
  logic                 ovf_q, ovf_d, err_q, err_d, acc_ovf, sq_ovf;
  logic                 ctrl_wr, start;

  assign ctrl_wr = avs_write && (avs_address == ADDR_CTRL);
  assign start   = ctrl_wr && avs_writedata[CTRL_START];
  assign e_shift = e_q >> 1;

`ifdef EXP_ACCEL_MOD_EN
  logic [WIDTH-1:0] mod_q, mod_sh_q, mod_sh_d;

  exp_accel_mul #(.WIDTH(WIDTH)) u_mul_acc (
    .a_i(acc_q), .b_i(b_q), .mod_i(mod_sh_q), .p_o(acc_p), .ovf_o(acc_ovf));
  exp_accel_mul #(.WIDTH(WIDTH)) u_mul_sq (
    .a_i(b_q), .b_i(b_q), .mod_i(mod_sh_q), .p_o(sq_p), .ovf_o(sq_ovf));
`else
  exp_accel_mul #(.WIDTH(WIDTH)) u_mul_acc (
    .a_i(acc_q), .b_i(b_q), .p_o(acc_p), .ovf_o(acc_ovf));
  exp_accel_mul #(.WIDTH(WIDTH)) u_mul_sq (
    .a_i(b_q), .b_i(b_q), .p_o(sq_p), .ovf_o(sq_ovf));
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    e_d      = e_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
`ifdef EXP_ACCEL_MOD_EN
    mod_sh_d = mod_sh_q;
`endif
    if (ctrl_wr && avs_writedata[CTRL_CLR_DONE]) done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      INIT: begin
        busy_d  = 1'b1;
        e_d     = exp_q;
        state_d = (exp_q == '0) ? DONE : ITER;
`ifdef EXP_ACCEL_MOD_EN
        mod_sh_d = mod_q;
        if (mod_q == '0) begin
          err_d   = 1'b1;
          acc_d   = '0;
          b_d     = '0;
          state_d = DONE;
        end else begin
          b_d   = base_q % mod_q;
          acc_d = (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
        end
`else
        b_d   = base_q;
        acc_d = WIDTH'(1);
`endif
      end
      ITER: begin
        if (e_q[0]) begin
          acc_d = acc_p;
          if (acc_ovf) ovf_d = 1'b1;
        end
        // The final square is discarded, so its overflow only counts if more bits remain.
        if (sq_ovf && (e_shift != '0)) ovf_d = 1'b1;
        b_d = sq_p;
        e_d = e_shift;
        if (e_shift == '0) state_d = DONE;
      end
      DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      e_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      e_q      <= e_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Software-visible registers accept writes at any time; the running op uses its own copies.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      base_q   <= '0;
      exp_q    <= '0;
      irq_en_q <= 1'b0;
    end else if (avs_write) begin
      if (avs_address == ADDR_CTRL) irq_en_q <= avs_writedata[CTRL_IRQ_EN];
      if (avs_address == ADDR_BASE) base_q   <= avs_writedata;
      if (avs_address == ADDR_EXP)  exp_q    <= avs_writedata[EXP_WIDTH-1:0];
    end
  end

`ifdef EXP_ACCEL_MOD_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mod_q    <= '0;
      mod_sh_q <= '0;
    end else begin
      mod_sh_q <= mod_sh_d;
      if (avs_write && (avs_address == ADDR_MOD)) mod_q <= avs_writedata;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    unique case (avs_address)
      ADDR_CTRL: begin
        rd_mux[STAT_BUSY]   = busy_q;
        rd_mux[STAT_DONE]   = done_q;
        rd_mux[STAT_OVF]    = ovf_q;
        rd_mux[STAT_IRQ_EN] = irq_en_q;
        rd_mux[STAT_ERR]    = err_q;
      end
      ADDR_BASE:   rd_mux = base_q;
      ADDR_EXP:    rd_mux[EXP_WIDTH-1:0] = exp_q;
      ADDR_RESULT: rd_mux = result_q;
`ifdef EXP_ACCEL_MOD_EN
      ADDR_MOD:    rd_mux = mod_q;
`endif
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  rdata_q <= '0;
    else if (avs_read)   rdata_q <= rd_mux;
  end

  assign avs_readdata = rdata_q;
  assign irq          = done_q & irq_en_q;

endmodule

// File: tb/tb_exp_accel_core.sv
// Directed bench for exp_accel_core; define EXP_ACCEL_MOD_EN to exercise the modular build.
module tb_exp_accel_core;

  logic        clk;
  logic        rst_n;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_accel_core #(.WIDTH(32), .EXP_WIDTH(32)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(posedge clk);
    #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read    = 1'b1;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  // Starts an op with irq_en set and returns the number of edges until irq rises.
  task automatic run_op(input logic [31:0] base, input logic [31:0] exp_v, output int cnt);
    wr(3'd1, base);
    wr(3'd2, exp_v);
    wr(3'd0, 32'h3);
    cnt = 0;
    while (!irq && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0h expected 0", irq); end
    n_cmp++;
    if (avs_readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %0h expected 0", avs_readdata);
    end
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), d);
      n_cmp++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %0h expected 0", a, d); end
    end
  endtask

  task automatic test_basic();
    int cnt;
    logic [31:0] d;
    run_op(32'd3, 32'd4, cnt);
    n_cmp++;
    if (cnt !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", cnt); end
    rd(3'd3, d);
    n_cmp++;
    if (d !== 32'd81) begin n_fail++; $display("FAIL basic_result: got %0d expected 81", d); end
    rd(3'd0, d);
    n_cmp++;
    if (d !== 32'h0A) begin n_fail++; $display("FAIL basic_status: got %0h expected a", d); end
  endtask

  task automatic test_edge_values();
    int cnt;
    logic [31:0] d;
    run_op(32'd7, 32'd0, cnt);
    n_cmp++;
    if (cnt !== 2) begin n_fail++; $display("FAIL exp0_latency: got %0d expected 2", cnt); end
    rd(3'd3, d);
    n_cmp++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL exp0_result: got %0d expected 1", d); end
    run_op(32'd0, 32'd5, cnt);
    n_cmp++;
    if (cnt !== 5) begin n_fail++; $display("FAIL base0_latency: got %0d expected 5", cnt); end
    rd(3'd3, d);
    n_cmp++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL base0_result: got %0d expected 0", d); end
  endtask

  task automatic test_overflow();
    int cnt;
    logic [31:0] d;
    run_op(32'd2, 32'd32, cnt);
    n_cmp++;
    if (cnt !== 8) begin n_fail++; $display("FAIL ovf_latency: got %0d expected 8", cnt); end
    rd(3'd3, d);
    n_cmp++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ovf_result: got %0h expected 0", d); end
    rd(3'd0, d);
    n_cmp++;
    if (d !== 32'h0E) begin n_fail++; $display("FAIL ovf_status: got %0h expected e", d); end
    run_op(32'd2, 32'd31, cnt);
    rd(3'd3, d);
    n_cmp++;
    if (d !== 32'h8000_0000) begin
      n_fail++; $display("FAIL pow31_result: got %0h expected 80000000", d);
    end
    rd(3'd0, d);
    n_cmp++;
    if (d !== 32'h0A) begin n_fail++; $display("FAIL pow31_status: got %0h expected a", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wr(3'd1, 32'd5);
    wr(3'd2, 32'd3);
    wr(3'd0, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %0h expected 0", irq); end
    rd(3'd0, d);
    n_cmp++;
    if (d !== 32'h02) begin n_fail++; $display("FAIL irq_masked_status: got %0h expected 2", d); end
    wr(3'd0, 32'h2);
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_enable: got %0h expected 1", irq); end
    rd(3'd3, d);
    n_cmp++;
    if (d !== 32'd125) begin n_fail++; $display("FAIL irq_result: got %0d expected 125", d); end
    wr(3'd0, 32'h6);
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr: got %0h expected 0", irq); end
    rd(3'd0, d);
    n_cmp++;
    if (d !== 32'h08) begin n_fail++; $display("FAIL irq_clr_status: got %0h expected 8", d); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    logic [31:0] d;
    wr(3'd1, 32'd2);
    wr(3'd2, 32'd10);
    wr(3'd0, 32'h3);
    wr(3'd2, 32'd3);
    rd(3'd0, d);
    n_cmp++;
    if (d[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %0h expected 1", d[0]); end
    wr(3'd0, 32'h3);
    wr(3'd1, 32'd9);
    cnt = 0;
    while (!irq && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout: got %0h expected 1", irq); end
    rd(3'd3, d);
    n_cmp++;
    if (d !== 32'd1024) begin n_fail++; $display("FAIL b2b_result: got %0d expected 1024", d); end
    rd(3'd2, d);
    n_cmp++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL b2b_exp_reg: got %0d expected 3", d); end
    rd(3'd1, d);
    n_cmp++;
    if (d !== 32'd9) begin n_fail++; $display("FAIL b2b_base_reg: got %0d expected 9", d); end
    wr(3'd0, 32'h4);
    repeat (20) @(posedge clk);
    #1;
    rd(3'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL b2b_no_restart: got %0h expected 0", d); end
  endtask

  task automatic test_reset_mid();
    int cnt;
    logic [31:0] d;
    wr(3'd1, 32'd3);
    wr(3'd2, 32'h0000_FFFF);
    wr(3'd0, 32'h3);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (avs_readdata !== 32'h0) begin
      n_fail++; $display("FAIL midrst_rdata: got %0h expected 0", avs_readdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd(3'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_status: got %0h expected 0", d); end
    rd(3'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_result: got %0h expected 0", d); end
`ifdef EXP_ACCEL_MOD_EN
    wr(3'd4, 32'hFFFF_FFFF);
`endif
    run_op(32'd2, 32'd10, cnt);
    n_cmp++;
    if (cnt !== 6) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 6", cnt); end
    rd(3'd3, d);
    n_cmp++;
    if (d !== 32'd1024) begin n_fail++; $display("FAIL midrst_pow: got %0d expected 1024", d); end
  endtask

  task automatic test_mod();
    int cnt;
    logic [31:0] d;
`ifdef EXP_ACCEL_MOD_EN
    wr(3'd4, 32'd497);
    rd(3'd4, d);
    n_cmp++;
    if (d !== 32'd497) begin n_fail++; $display("FAIL mod_reg: got %0d expected 497", d); end
    run_op(32'd4, 32'd13, cnt);
    rd(3'd3, d);
    n_cmp++;
    if (d !== 32'd445) begin n_fail++; $display("FAIL mod_result: got %0d expected 445", d); end
    wr(3'd4, 32'd0);
    run_op(32'd4, 32'd13, cnt);
    n_cmp++;
    if (cnt !== 2) begin n_fail++; $display("FAIL mod0_latency: got %0d expected 2", cnt); end
    rd(3'd3, d);
    n_cmp++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL mod0_result: got %0d expected 0", d); end
    rd(3'd0, d);
    n_cmp++;
    if (d !== 32'h1A) begin n_fail++; $display("FAIL mod0_status: got %0h expected 1a", d); end
`else
    cnt = 0;
    wr(3'd4, 32'd497);
    rd(3'd4, d);
    n_cmp++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_addr4: got %0d expected 0", d); end
    run_op(32'd4, 32'd13, cnt);
    rd(3'd3, d);
    n_cmp++;
    if (d !== 32'h0400_0000) begin
      n_fail++; $display("FAIL plain_result: got %0h expected 4000000", d);
    end
`endif
  endtask

  initial begin
    rst_n         = 1'b0;
    avs_address   = 3'd0;
    avs_write     = 1'b0;
    avs_writedata = 32'h0;
    avs_read      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
`ifdef EXP_ACCEL_MOD_EN
    wr(3'd4, 32'hFFFF_FFFF);
`endif
    test_basic();
    test_edge_values();
`ifndef EXP_ACCEL_MOD_EN
    test_overflow();
`endif
    test_irq();
    test_back_to_back();
    test_reset_mid();
    test_mod();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
